i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 108 ++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// I2S transmitter: double-buffered 32-bit stereo sample serialised MSB first with SCK/WS generation.
// Optional feature macro: I2S_TX_MUTE_EN adds a mute input sampled at each frame boundary.
module i2s_tx #(
  parameter int HALF_DIV = 4
) (
  input  logic        clk,
  input  logic        n_rst,
`ifdef I2S_TX_MUTE_EN
  input  logic        mute,
`endif
  input  logic [31:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        sck,
  output logic        ws,
  output logic        sd,
  output logic        underrun
);

  localparam logic [7:0] DIV_MAX = 8'(HALF_DIV - 1);

  logic [7:0]  div_q, div_d;
  logic        sck_q, sck_d;
  logic [4:0]  s_q, s_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] hold_q, hold_d;
  logic        ready_q, ready_d;
  logic        ws_q, ws_d;
  logic        sd_q, sd_d;
  logic        ur_q, ur_d;

  logic mute_w;
`ifdef I2S_TX_MUTE_EN
  assign mute_w = mute;
`else
  assign mute_w = 1'b0;
`endif

  logic wrap, fall, accept;

  always_comb begin
    div_d   = div_q;
    sck_d   = sck_q;
    s_d     = s_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    ready_d = ready_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    ur_d    = 1'b0;

    wrap   = (div_q == DIV_MAX);
    fall   = wrap && sck_q;
    accept = sample_valid && ready_q;

    div_d = wrap ? 8'd0 : div_q + 8'd1;
    if (wrap) sck_d = ~sck_q;

    if (fall) begin
      s_d = s_q + 5'd1;
      if (s_q == 5'd31) begin
        // Frame boundary: an empty holding register always sends silence and is flagged.
        shift_d = (!ready_q && !mute_w) ? hold_q : 32'h0;
        ur_d    = ready_q;
        ready_d = 1'b1;
      end
      sd_d = shift_d[5'd31 - s_d];
      ws_d = (s_d >= 5'd15) && (s_d <= 5'd30);
    end

    // A write on an empty-holding boundary lands after the zero frame was loaded.
    if (accept) begin
      hold_d  = sample_data;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_q   <= 8'd0;
      sck_q   <= 1'b0;
      s_q     <= 5'd31;
      shift_q <= 32'h0;
      hold_q  <= 32'h0;
      ready_q <= 1'b1;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      sck_q   <= sck_d;
      s_q     <= s_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      ur_q    <= ur_d;
    end
  end

  assign sample_ready = ready_q;
  assign sck          = sck_q;
  assign ws           = ws_q;
  assign sd           = sd_q;
  assign underrun     = ur_q;

endmodule
